// File: rtl/mole_hit_judge.sv
// Whack-a-mole player-side judge: requests moles, times the reaction window, scores hits/misses.
// Optional build macro MISS_PENALTY_EN: each miss decrements the score (floored at 0).
module mole_hit_judge #(
  parameter int unsigned NUM_HOLES     = 18,
  parameter int unsigned WINDOW_CYCLES = 25_000_000,
  parameter int unsigned RESULT_CYCLES = 12_500_000,
  parameter int unsigned ROUNDS        = 16,
  parameter int unsigned SCORE_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_HOLES-1:0] switches,
  input  logic [NUM_HOLES-1:0] mole_leds,
  output logic                 trigger,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic [SCORE_W-1:0]   score,
  output logic [4:0]           round_cnt,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES);
  localparam int unsigned RES_W = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [RES_W-1:0] RES_LAST = RES_W'(RESULT_CYCLES - 1);
  localparam logic [4:0]       ROUNDS_L = 5'(ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SETTLE,
    S_ACTIVE,
    S_RESULT,
    S_DONE
  } state_t;

  state_t               state;
  logic [NUM_HOLES-1:0] sw_meta;
  logic [NUM_HOLES-1:0] sw_s;
  logic [NUM_HOLES-1:0] sw_prev;
  logic                 start_prev;
  logic [1:0]           settle_cnt;
  logic [WIN_W-1:0]     win_cnt;
  logic [RES_W-1:0]     res_cnt;

  logic [NUM_HOLES-1:0] tog;
  logic                 start_rise;
  logic                 is_hit;
  logic                 is_miss;

  // A toggle on the last window cycle takes priority over the timeout.
  always_comb begin
    tog        = sw_s ^ sw_prev;
    start_rise = start & ~start_prev;
    is_hit     = (tog != '0) && ((tog & ~mole_leds) == '0);
    is_miss    = ((tog != '0) && !is_hit) || ((tog == '0) && (win_cnt == WIN_LAST));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      sw_meta    <= '0;
      sw_s       <= '0;
      sw_prev    <= '0;
      start_prev <= 1'b0;
      settle_cnt <= '0;
      win_cnt    <= '0;
      res_cnt    <= '0;
      trigger    <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      score      <= '0;
      round_cnt  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      sw_meta    <= switches;
      sw_s       <= sw_meta;
      sw_prev    <= sw_s;
      start_prev <= start;
      trigger    <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;

      case (state)
        S_IDLE, S_DONE: begin
          if (start_rise) begin
            state     <= S_ARM;
            score     <= '0;
            round_cnt <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
          end
        end

        S_ARM: begin
          state      <= S_SETTLE;
          trigger    <= 1'b1;
          settle_cnt <= '0;
          win_cnt    <= '0;
        end

        // Gives the generator time to update its display before judging.
        S_SETTLE: begin
          win_cnt <= '0;
          if (settle_cnt == 2'd2) begin
            state <= S_ACTIVE;
          end else begin
            settle_cnt <= settle_cnt + 2'd1;
          end
        end

        S_ACTIVE: begin
          if (is_hit) begin
            hit_pulse <= 1'b1;
            if (score != '1) begin
              score <= score + SCORE_W'(1);
            end
            state     <= S_RESULT;
            round_cnt <= round_cnt + 5'd1;
            res_cnt   <= '0;
          end else if (is_miss) begin
            miss_pulse <= 1'b1;
`ifdef MISS_PENALTY_EN
            if (score != '0) begin
              score <= score - SCORE_W'(1);
            end
`else
            score <= score;
`endif
            state     <= S_RESULT;
            round_cnt <= round_cnt + 5'd1;
            res_cnt   <= '0;
          end else begin
            win_cnt <= win_cnt + WIN_W'(1);
          end
        end

        S_RESULT: begin
          if (res_cnt == RES_LAST) begin
            if (round_cnt == ROUNDS_L) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_ARM;
            end
          end else begin
            res_cnt <= res_cnt + RES_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mole_hit_judge.md
# mole_hit_judge

Player-side responder for the whack-a-mole game loop. It requests a new mole from the random mole generator with a one-cycle `trigger` pulse. It then watches the player's 18 slide switches during a timed reaction window and judges each round as a hit or a miss. It keeps the score and round count, and signals game completion.

## Interface
Parameters:
- `NUM_HOLES`, 18: width of the mole LED and switch vectors.
- `WINDOW_CYCLES`, 25_000_000: reaction window length in clk cycles (≥2).
- `RESULT_CYCLES`, 12_500_000: hold time after each judgement before the next mole (≥1).
- `ROUNDS`, 16: rounds per game (1..31).
- `SCORE_W`, 8: score counter width.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  synchronous level; its rising edge starts a game.
- `switches`  in  NUM_HOLES  raw player switches, asynchronous.
- `mole_leds`  in  NUM_HOLES  one-hot mole display from the generator.
- `trigger`  out  1  registered one-cycle request for a new mole.
- `hit_pulse`  out  1  one-cycle pulse on a correct whack.
- `miss_pulse`  out  1  one-cycle pulse on a wrong hole or a timeout.
- `score`  out  SCORE_W  hits this game.
- `round_cnt`  out  5  rounds judged this game.
- `busy`  out  1  high from the ARM state through the RESULT state.
- `done`  out  1  high in the DONE state.

## Operation
- Switch front end: a 2-flop synchronizer feeds `sw_s`, and `sw_prev` is updated every cycle in every state. `tog = sw_s ^ sw_prev`. Toggles seen outside the ACTIVE state are discarded.
- States: IDLE, ARM, SETTLE, ACTIVE, RESULT, DONE.
- IDLE: on a `start` rising edge, go to ARM and clear `score` and `round_cnt`.
- ARM (1 cycle): go to SETTLE; `trigger` is high during the following cycle. The generator needs 2 cycles from the trigger edge to update its display.
- SETTLE (3 cycles): the window counter is held at 0. Then go to ACTIVE.
- ACTIVE: the window counter increments every cycle. Each cycle is evaluated in priority order:
  - `tog != 0` and `(tog & ~mole_leds) == 0` → hit: `hit_pulse`, `score` +1 saturating at 2^SCORE_W−1, go to RESULT.
  - `tog != 0` otherwise (wrong hole, multiple holes, or `mole_leds` == 0) → miss, go to RESULT.
  - counter == WINDOW_CYCLES−1 and `tog == 0` → miss (timeout), go to RESULT.
- RESULT: `round_cnt` +1 on entry. Stay for RESULT_CYCLES cycles, then go to DONE if `round_cnt == ROUNDS`, else go to ARM.
- DONE: `done` = 1. A `start` rising edge clears `score` and `round_cnt` and goes to ARM.
- A `start` edge in any state other than IDLE or DONE is ignored.

## Timing
- Reset values: state IDLE; all outputs 0; synchronizer, `sw_prev`, the start edge register and all counters 0.
- Start edge sampled at edge N: state is ARM at N+1, `trigger` = 1 during cycle N+2 only, state is ACTIVE at N+5.
- Switch change to judgement: the pin change reaches `tog` after 2 edges. `hit_pulse`/`miss_pulse` are registered and go high on the edge that enters RESULT, for exactly 1 cycle.
- A toggle on the final window cycle beats the timeout and is judged as a hit or miss on its merits. `hit_pulse` and `miss_pulse` are never high together.
- The window counter is `$clog2(WINDOW_CYCLES)` bits and never wraps; it is reset to 0 in SETTLE.
- Asserting reset mid-round aborts immediately to the reset state, and no pulse is emitted.

## Configuration
- `MISS_PENALTY_EN` defined: each miss decrements `score` by 1, saturating at 0.
- `MISS_PENALTY_EN` undefined: a miss leaves `score` unchanged.

## Test plan
Parameters for all scenarios: WINDOW_CYCLES=20, RESULT_CYCLES=4, ROUNDS=3.
- Reset, then a `start` pulse → `trigger` high for exactly one cycle, 2 cycles after the start edge; `busy`=1.
- `mole_leds`=18'h00010; toggle `switches[4]` 5 cycles into ACTIVE → `hit_pulse` one cycle, `score`=1, `round_cnt`=1, no `miss_pulse`.
- `mole_leds`=18'h00010; toggle `switches[7]` → `miss_pulse`, `score` unchanged (0 → 0 with the macro, since the penalty floors at 0).
- No toggle for the whole window → `miss_pulse` exactly 20 cycles after entering ACTIVE.
- Three rounds (hit, hit, timeout) → `done`=1, `score`=2 (1 with `MISS_PENALTY_EN`). A new `start` → `score`=0, `round_cnt`=0, `trigger` pulses again.
- Assert reset mid-ACTIVE → all outputs 0 on the next cycle, state IDLE; a toggle in IDLE produces no pulse.
